// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding and SRAM write-enable constants.
package im_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] WEN_FULL = 4'b1111;
    localparam logic [3:0] WEN_NONE = 4'b0000;

endpackage

// File: rtl/im_boot_loader_byte_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// word_valid pulses in the cycle the fourth byte is accepted.
module im_boot_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [31:0] sr;

    // Newest byte enters at the top so the first byte ends up in [7:0].
    assign word       = {byte_in, sr[31:8]};
    assign word_valid = byte_en && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            sr  <= word;
        end
    end

endmodule

// File: rtl/im_boot_loader.sv
// Streams a length-prefixed, checksummed image into instruction SRAM
// and holds the core in reset until the image has been verified.
module im_boot_loader
    import im_boot_loader_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 16'h0000,
    parameter int unsigned          MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [3:0]        im_w_en,
    output logic [ADDR_W-1:0] im_address,
    output logic [31:0]       im_write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    state_t            state;
    state_t            state_d;
    logic              clear;
    logic              fire;
    logic              word_valid;
    logic [31:0]       word;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W-1:0] word_cnt;
    logic [31:0]       csum;
    logic [3:0]        w_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    assign busy     = (state == S_LEN) || (state == S_DATA) ||
                      (state == S_CSUM);
    assign in_ready = busy;
    assign fire     = in_valid && in_ready;
    assign done     = (state == S_DONE);
    assign cpu_rst  = (state == S_DONE);
    assign error    = (state == S_ERR);

    assign im_w_en       = w_en_q;
    assign im_address    = addr_q;
    assign im_write_data = wdata_q;
    assign words_loaded  = word_cnt;

    assign cnt_next = {1'b0, word_cnt} + {{ADDR_W{1'b0}}, 1'b1};

    im_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_en    (fire),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state;
        clear   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    clear   = 1'b1;
                end
            end
            S_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0 || word > MAX_WORDS)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid && cnt_next == len_q)
                    state_d = S_CSUM;
            end
            S_CSUM: begin
                if (word_valid)
                    state_d = (word == csum) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            csum     <= 32'd0;
            w_en_q   <= WEN_NONE;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 32'd0;
        end else begin
            state  <= state_d;
            w_en_q <= WEN_NONE;
            if (clear) begin
                len_q    <= '0;
                word_cnt <= '0;
                csum     <= 32'd0;
            end
            if (state == S_LEN && word_valid)
                len_q <= word[ADDR_W:0];
            // Register the completed word so the write lands one cycle later.
            if (state == S_DATA && word_valid) begin
                w_en_q   <= WEN_FULL;
                addr_q   <= BASE_ADDR + word_cnt;
                wdata_q  <= word;
                csum     <= csum + word;
                word_cnt <= word_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized self-checking bench: two loader builds share one byte stream
// and are compared every cycle against a byte-stream level model.
module tb_im_boot_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy   [2];
    logic [3:0]  wen   [2];
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic        crst  [2];
    logic        bsy   [2];
    logic        dn    [2];
    logic        er    [2];
    logic [15:0] wl    [2];

    int n_tests = 0;
    int n_fail  = 0;

    im_boot_loader u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .im_w_en(wen[0]), .im_address(addr[0]),
        .im_write_data(wdata[0]), .cpu_rst(crst[0]), .busy(bsy[0]),
        .done(dn[0]), .error(er[0]), .words_loaded(wl[0])
    );

    im_boot_loader #(
        .ADDR_W(16), .BASE_ADDR(16'h0010), .MAX_WORDS(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .im_w_en(wen[1]), .im_address(addr[1]),
        .im_write_data(wdata[1]), .cpu_rst(crst[1]), .busy(bsy[1]),
        .done(dn[1]), .error(er[1]), .words_loaded(wl[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Model: interprets the accepted byte stream of each build.
    logic [15:0] m_base [2] = '{16'h0000, 16'h0010};
    int unsigned m_max  [2] = '{16384, 4};
    bit          known = 0;
    bit          m_load [2];
    int          m_stat [2];
    int          m_k    [2];
    int          m_cnt  [2];
    logic [31:0] m_n    [2];
    logic [31:0] m_cs   [2];
    logic [31:0] m_cur  [2];
    bit          m_pend [2];
    logic [15:0] m_pa   [2];
    logic [31:0] m_pd   [2];

    logic [31:0] mem0 [int];
    logic [31:0] mem1 [int];
    int          wr   [2] = '{0, 0};

    always @(negedge clk) begin
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready%0d", i), rdy[i], m_load[i]);
                chk($sformatf("busy%0d", i), bsy[i], m_load[i]);
                chk($sformatf("done%0d", i), dn[i], m_stat[i] == 1);
                chk($sformatf("cpu_rst%0d", i), crst[i], m_stat[i] == 1);
                chk($sformatf("error%0d", i), er[i], m_stat[i] == 2);
                chk($sformatf("words_loaded%0d", i), wl[i], m_cnt[i]);
                chk($sformatf("w_en%0d", i), wen[i],
                    m_pend[i] ? 4'hF : 4'h0);
                if (m_pend[i]) begin
                    chk($sformatf("addr%0d", i), addr[i], m_pa[i]);
                    chk($sformatf("wdata%0d", i), wdata[i], m_pd[i]);
                end
                if (wen[i] == 4'hF) begin
                    if (i == 0) mem0[int'(addr[i])] = wdata[i];
                    else        mem1[int'(addr[i])] = wdata[i];
                    wr[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_load[i] = 0; m_stat[i] = 0; m_k[i] = 0;
                m_cnt[i] = 0; m_cs[i] = 0; m_pend[i] = 0;
            end else begin
                m_pend[i] = 0;
                if (!m_load[i]) begin
                    if (start) begin
                        m_load[i] = 1; m_stat[i] = 0; m_k[i] = 0;
                        m_cnt[i] = 0; m_cs[i] = 0;
                    end
                end else if (in_valid) begin
                    m_cur[i] = {in_data, m_cur[i][31:8]};
                    if (m_k[i] % 4 == 3) begin
                        int j;
                        j = m_k[i] / 4;
                        if (j == 0) begin
                            m_n[i] = m_cur[i];
                            if (m_n[i] == 0 || m_n[i] > m_max[i]) begin
                                m_load[i] = 0; m_stat[i] = 2;
                            end
                        end else if (j <= int'(m_n[i])) begin
                            m_pend[i] = 1;
                            m_pa[i] = m_base[i] + 16'(m_cnt[i]);
                            m_pd[i] = m_cur[i];
                            m_cs[i] += m_cur[i];
                            m_cnt[i]++;
                        end else begin
                            m_load[i] = 0;
                            m_stat[i] = (m_cur[i] == m_cs[i]) ? 1 : 2;
                        end
                    end
                    m_k[i]++;
                end
            end
        end
        if (!rst) known = 1;
    end

    logic [31:0] img [$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        int g;
        int t;
        g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        repeat (g) begin in_valid = 0; tick(); end
        in_valid = 1; in_data = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (rdy[0]) break;
            t++;
            if (t > 40) begin
                chk("handshake_timeout", 1, 0);
                break;
            end
        end
        tick();
    endtask

    task automatic send_word(logic [31:0] w, int gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic pulse_start();
        in_valid = 0; start = 1; tick(); start = 0;
    endtask

    task automatic run_load(logic [31:0] n, logic [31:0] cs, int gap);
        pulse_start();
        send_word(n, gap);
        if (n != 0 && n <= 16384) begin
            foreach (img[i]) send_word(img[i], gap);
            send_word(cs, gap);
        end
        in_valid = 0;
        repeat (2) tick();
    endtask

    task automatic junk(int cycles);
        repeat (cycles) begin
            in_valid = 1; in_data = 8'($urandom); tick();
        end
        in_valid = 0;
    endtask

    function automatic logic [31:0] img_sum();
        logic [31:0] s = 0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction

    initial begin
        int w0;
        logic [31:0] cs;
        rst = 0; start = 0; in_valid = 0; in_data = 0;
        repeat (3) tick();
        @(negedge clk); #1;
        chk("reset_busy", bsy[0], 0);
        chk("reset_cpu_rst", crst[0], 0);
        chk("reset_addr", addr[0], 16'h0000);
        chk("reset_addr_b16", addr[1], 16'h0010);
        tick();
        rst = 1;
        junk(4);

        img = '{32'h00000013, 32'h00100093};
        run_load(2, 32'h001000A6, 0);
        chk("single_done", dn[0], 1);
        chk("single_cpu_rst", crst[0], 1);
        chk("single_words", wl[0], 2);
        chk("single_mem0", mem0[0], 32'h00000013);
        chk("single_mem1", mem0[1], 32'h00100093);
        chk("single_b16_mem", mem1[16], 32'h00000013);
        chk("single_b16_mem17", mem1[17], 32'h00100093);

        w0 = wr[0];
        run_load(2, 32'h00000000, 0);
        chk("badcs_writes", wr[0] - w0, 2);
        chk("badcs_error", er[0], 1);
        chk("badcs_cpu_rst", crst[0], 0);
        chk("badcs_done", dn[0], 0);

        w0 = wr[0];
        run_load(0, 0, 0);
        chk("len0_error", er[0], 1);
        chk("len0_writes", wr[0] - w0, 0);

        w0 = wr[0];
        run_load(16385, 0, 0);
        chk("lenmax1_error", er[0], 1);
        chk("lenmax1_writes", wr[0] - w0, 0);

        img = '{1, 2, 3, 4, 5};
        run_load(5, 15, 0);
        chk("n5_done_big", dn[0], 1);
        chk("n5_err_small", er[1], 1);

        img = '{1, 2, 3, 4};
        run_load(4, 10, 1);
        chk("n4_done_small", dn[1], 1);

        junk(5);
        mem0.delete();
        img = '{32'h00000013, 32'h00100093};
        run_load(2, 32'h001000A6, 3);
        chk("gap_done", dn[0], 1);
        chk("gap_mem0", mem0[0], 32'h00000013);
        chk("gap_mem1", mem0[1], 32'h00100093);

        repeat (8) begin
            int n;
            n = int'($urandom_range(1, 4));
            img.delete();
            repeat (n) img.push_back($urandom);
            cs = img_sum();
            if ($urandom_range(0, 3) == 0) cs ^= 32'h1;
            junk(int'($urandom_range(0, 3)));
            run_load(32'(n), cs, int'($urandom_range(0, 2)));
        end

        w0 = wr[0];
        img = '{32'h00000013, 32'h00100093};
        pulse_start();
        send_word(2, 0);
        send_word(img[0], 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        in_valid = 0; rst = 0; tick(); rst = 1;
        @(negedge clk); #1;
        chk("rstmid_busy", bsy[0], 0);
        chk("rstmid_ready", rdy[0], 0);
        chk("rstmid_words", wl[0], 0);
        chk("rstmid_w_en", wen[0], 0);
        chk("rstmid_addr", addr[0], 16'h0000);
        chk("rstmid_writes", wr[0] - w0, 1);
        tick();
        junk(3);
        run_load(2, 32'h001000A6, 0);
        chk("rstmid_reload_done", dn[0], 1);

        mem1.delete();
        pulse_start();
        @(negedge clk); #1;
        chk("reload_cpu_rst", crst[0], 0);
        chk("reload_busy", bsy[0], 1);
        tick();
        img = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
        send_word(3, 0);
        foreach (img[i]) send_word(img[i], 0);
        send_word(img_sum(), 0);
        in_valid = 0;
        repeat (2) tick();
        chk("reload_done", dn[1], 1);
        chk("reload_b16_16", mem1[16], 32'hDEADBEEF);
        chk("reload_b16_18", mem1[18], 32'h0BADF00D);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Upstream stage of the RV32I single-cycle core.
- Receives a byte stream from an external host over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words into instruction SRAM through the SRAM write port (w_en/address/write_data), which the core itself never drives.
- Holds the core in reset until a complete image with a valid checksum has been written, then releases it.

Parameters:
- ADDR_W, 16, width of the SRAM word address (matches the SRAM address port).
- BASE_ADDR, 16'h0000, SRAM word address of the first image word.
- MAX_WORDS, 16384, largest accepted image length in words; must be ≤ 2^ADDR_W − BASE_ADDR.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load (honoured in IDLE, DONE and ERR).
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  image byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_w_en  out  4  SRAM byte write enables (4'b1111 or 4'b0000).
- im_address  out  ADDR_W  SRAM word address.
- im_write_data  out  32  SRAM write data.
- cpu_rst  out  1  active-low reset to the core; 0 holds the core in reset.
- busy  out  1  load in progress (LEN, DATA or CSUM).
- done  out  1  image loaded and verified.
- error  out  1  load failed.
- words_loaded  out  ADDR_W  count of data words written during the current/last load.

Behaviour:
- Reset (rst=0 at a clock edge) forces the following; highest priority; a partial word is discarded with no write:
  - state=IDLE; byte counter=0; word counter=0; checksum accumulator=0.
  - im_w_en=0, im_address=BASE_ADDR, im_write_data=0.
  - cpu_rst=0, busy=0, done=0, error=0, words_loaded=0, in_ready=0.
- Byte transfer occurs when in_valid && in_ready.
  - in_ready=1 exactly in LEN, DATA, CSUM; 0 otherwise.
  - Bytes presented while in_ready=0 are ignored and not buffered.
- Word assembly: 2-bit byte counter. First byte → bits [7:0], fourth → [31:24]. The counter wraps to 0 after the fourth byte.
- State machine:
  - IDLE: start → LEN; clear counters and checksum.
  - LEN: on the fourth byte the word is the length N.
    - N==0 or N>MAX_WORDS → ERR.
    - Otherwise latch N → DATA.
  - DATA: each completed word W is registered for a write.
    - The next cycle drives im_w_en=4'b1111, im_address=BASE_ADDR+word counter, im_write_data=W. im_w_en is 0 in all other cycles.
    - checksum += W (mod 2^32); word counter and words_loaded increment.
    - After the N-th word → CSUM.
  - CSUM: on the fourth byte compare the received word with the checksum.
    - Equal → DONE.
    - Unequal → ERR.
  - DONE: cpu_rst=1, done=1. start → LEN, with cpu_rst=0 and done=0 from the next cycle.
  - ERR: error=1, cpu_rst=0. start → LEN, clearing error.
- start is ignored in LEN/DATA/CSUM.
- cpu_rst is 1 only in DONE. It is registered and rises one cycle after the checksum word's last byte is accepted.
- Latency: last byte of a data word accepted at cycle t → SRAM write at t+1. Back-to-back writes occur at most every 4 cycles.
- A start pulse coinciding with reset is lost.
- Address arithmetic never wraps because N≤MAX_WORDS.

Decomposition:
- Shared package: state encoding (IDLE, LEN, DATA, CSUM, DONE, ERR) and the full-word write-enable constant 4'b1111.
- One natural sub-module, byte_packer: byte counter, shift register and word_valid pulse; reset and clear inputs. The FSM, counters and checksum stay in im_boot_loader.

Test Plan:
- Single load: start; stream N=2, words 32'h00000013, 32'h00100093, checksum 32'h001000A6, bytes back-to-back.
  - Writes at address 0 and 1 with those values, each one cycle after its 4th byte.
  - Then done=1, cpu_rst=1, words_loaded=2.
- Bad checksum: same image with trailer 32'h00000000.
  - Both words are written, then error=1, cpu_rst stays 0, done=0.
- Length checks:
  - N=0 → ERR with no SRAM write.
  - N=MAX_WORDS+1 → ERR with no SRAM write.
- Gapped stream: random in_valid gaps, including bytes presented in IDLE.
  - IDLE bytes are ignored.
  - Written data is unchanged vs the back-to-back run.
- Reset mid-operation: rst=0 after 2 bytes of the second data word.
  - Next cycle: IDLE, all outputs at reset values, no extra write.
  - A subsequent full load succeeds.
- Reload: start in DONE.
  - cpu_rst drops to 0 next cycle.
  - A second image with BASE_ADDR=16'h0010 (separate build) writes from address 16.
